// File: rtl/bnn_mem_sequencer_if.sv
// Control and memory-bus bundle for the BNN address sequencer.
// The master side issues start/stall/clear; the slave (sequencer) drives the buffer bus.
interface bnn_mem_sequencer_if #(
  parameter int AW = 5,
  parameter int CW = 1
);
  logic          iCLR;
  logic          iSTART;
  logic          iSTALL;
  logic [AW-1:0] oADDR;
  logic          oRd_EN;
  logic          oWr_EN;
  logic [CW-1:0] oCH;
  logic          oBUSY;
  logic          oDONE;

  modport master (
    output iCLR, iSTART, iSTALL,
    input  oADDR, oRd_EN, oWr_EN, oCH, oBUSY, oDONE
  );

  modport slave (
    input  iCLR, iSTART, iSTALL,
    output oADDR, oRd_EN, oWr_EN, oCH, oBUSY, oDONE
  );
endinterface

// File: rtl/bnn_mem_sequencer.sv
// Address sequencer: NCH passes of LEN reads per START, optional write-back pass
// after each read pass when BNN_SEQ_WRITEBACK_EN is defined.
module bnn_mem_sequencer #(
  parameter int AW      = 5,
  parameter int LEN     = 20,
  parameter int NCH     = 1,
  parameter int CW      = 1,
  parameter int RD_BASE = 0,
  parameter int WR_BASE = 0,
  parameter int STRIDE  = 20
) (
  input logic iCLK,
  input logic iRSTn,
  bnn_mem_sequencer_if.slave bus
);

`ifdef BNN_SEQ_WRITEBACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} stateT;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DONE = 2'd3} stateT;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(LEN - 1);

  // Bad parameter sets stop elaboration rather than producing a silently broken sequencer.
  if (LEN < 1 || LEN > (1 << AW) || NCH < 1 || (1 << CW) < NCH ||
      RD_BASE < 0 || WR_BASE < 0 || STRIDE < 0) begin : gBadParams
    $error("bnn_mem_sequencer: illegal parameter combination");
  end

  stateT         state;
  logic [AW-1:0] idx;
  logic [CW-1:0] ch;
  logic          lastWord;
  logic          moreCh;

  assign lastWord = (idx == LAST_IDX);
  assign moreCh   = (32'(ch) < 32'(NCH - 1));

  always_ff @(posedge iCLK) begin
    if (!iRSTn || bus.iCLR) begin
      state <= IDLE;
      idx   <= '0;
      ch    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.iSTART) state <= READ;
        READ: if (!bus.iSTALL) begin
          if (lastWord) begin
            idx <= '0;
`ifdef BNN_SEQ_WRITEBACK_EN
            state <= WRITE;
`else
            if (moreCh) ch <= ch + 1'b1;
            else        state <= DONE;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef BNN_SEQ_WRITEBACK_EN
        WRITE: if (!bus.iSTALL) begin
          if (lastWord) begin
            idx <= '0;
            if (moreCh) begin
              ch    <= ch + 1'b1;
              state <= READ;
            end else begin
              state <= DONE;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          ch    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses are summed at 32 bits and truncated, so oversize bases wrap silently.
  always_comb begin
    bus.oADDR  = '0;
    bus.oRd_EN = 1'b0;
    bus.oWr_EN = 1'b0;
    case (state)
      READ: begin
        bus.oADDR  = AW'(32'(RD_BASE) + 32'(ch) * 32'(STRIDE) + 32'(idx));
        bus.oRd_EN = !bus.iSTALL;
      end
`ifdef BNN_SEQ_WRITEBACK_EN
      WRITE: begin
        bus.oADDR  = AW'(32'(WR_BASE) + 32'(ch) * 32'(STRIDE) + 32'(idx));
        bus.oWr_EN = !bus.iSTALL;
      end
`endif
      default: ;
    endcase
  end

  assign bus.oCH   = ch;
  assign bus.oBUSY = (state != IDLE);
  assign bus.oDONE = (state == DONE);

endmodule
